// File: rtl/risc_controller.sv
// risc_controller: 8-phase fetch/execute sequencer for the 8-bit RISC core.
//   Inputs : clk, rst (async, active high), opcode[2:0] (IR opcode field),
//            zero (accumulator-is-zero), go (resume request while halted).
//   Outputs: sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e (datapath
//            strobes), halt, phase[2:0], instr_cnt[CNT_WIDTH-1:0].
// Phases 0-3 fetch the instruction, 4 bumps the PC, 5-7 execute. Strobes are
// decoded combinationally from the phase, latched opcode and halt flag.
module risc_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           opcode,
  input  logic                 zero,
  input  logic                 go,
  output logic                 sel,
  output logic                 rd,
  output logic                 ld_ir,
  output logic                 inc_pc,
  output logic                 ld_pc,
  output logic                 ld_ac,
  output logic                 wr,
  output logic                 data_e,
  output logic                 halt,
  output logic [2:0]           phase,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    OP_HLT = 3'b000, OP_SKZ = 3'b001, OP_ADD = 3'b010, OP_AND = 3'b011,
    OP_XOR = 3'b100, OP_LDA = 3'b101, OP_STO = 3'b110, OP_JMP = 3'b111
  } op_e;

  logic [2:0]           phase_q, phase_d;
  logic                 halted_q, halted_d;
  op_e                  op_q, op_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic is_hlt, is_skz, is_sto, is_jmp, is_alu;

  assign is_hlt = (op_q == OP_HLT);
  assign is_skz = (op_q == OP_SKZ);
  assign is_sto = (op_q == OP_STO);
  assign is_jmp = (op_q == OP_JMP);
  assign is_alu = (op_q == OP_ADD) || (op_q == OP_AND) ||
                  (op_q == OP_XOR) || (op_q == OP_LDA);

  // Next state
  always_comb begin
    phase_d  = phase_q + 3'd1;
    halted_d = halted_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    // opcode is only trusted on the edge closing phase 3 (IR load complete)
    if (phase_q == 3'd3) op_d = op_e'(opcode);
    if (halted_q) begin
      // parked in phase 4; go resumes straight into the execute phases
      if (go) begin
        halted_d = 1'b0;
        phase_d  = 3'd5;
      end else begin
        phase_d  = 3'd4;
      end
    end else if (phase_q == 3'd4 && is_hlt) begin
      halted_d = 1'b1;
      phase_d  = 3'd4;
    end
    if (phase_q == 3'd7) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= 3'd0;
      halted_q <= 1'b0;
      op_q     <= OP_HLT;
      cnt_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

  // Strobe decode
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    case (phase_q)
      3'd0: sel = 1'b1;
      3'd1: begin sel = 1'b1; rd = 1'b1; end
      3'd2, 3'd3: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
      // PC bumps only on entry to phase 4, so a parked HLT advances it once
      3'd4: begin inc_pc = !halted_q; halt = is_hlt; end
      3'd5: rd = is_alu;
      3'd6: begin
        rd     = is_alu;
        inc_pc = is_skz & zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      default: begin
        rd     = is_alu;
        ld_ac  = is_alu;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
    endcase
  end

  assign phase     = phase_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_risc_controller.sv
// Directed, table-driven bench for risc_controller.
module tb_risc_controller;

  logic        clk, rst, zero, go;
  logic [2:0]  opcode;
  logic        sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0]  phase;
  logic [15:0] instr_cnt;
  logic        sel4, rd4, ld_ir4, inc_pc4, ld_pc4, ld_ac4, wr4, data_e4, halt4;
  logic [2:0]  phase4;
  logic [3:0]  instr_cnt4;

  int errors = 0;
  int checks = 0;

  risc_controller #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .go(go),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt),
    .phase(phase), .instr_cnt(instr_cnt)
  );

  risc_controller #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .go(go),
    .sel(sel4), .rd(rd4), .ld_ir(ld_ir4), .inc_pc(inc_pc4), .ld_pc(ld_pc4),
    .ld_ac(ld_ac4), .wr(wr4), .data_e(data_e4), .halt(halt4),
    .phase(phase4), .instr_cnt(instr_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe bundle: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_P0   = 9'b100000000;
  localparam logic [8:0] S_P1   = 9'b110000000;
  localparam logic [8:0] S_P2   = 9'b111000000;
  localparam logic [8:0] S_INC  = 9'b000100000;
  localparam logic [8:0] S_RD   = 9'b010000000;
  localparam logic [8:0] S_RDAC = 9'b010001000;
  localparam logic [8:0] S_DE   = 9'b000000010;
  localparam logic [8:0] S_WRDE = 9'b000000110;
  localparam logic [8:0] S_LDPC = 9'b000010000;
  localparam logic [8:0] S_INCH = 9'b000100001;
  localparam logic [8:0] S_HALT = 9'b000000001;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic       g;
    logic [8:0] strb;
    logic [2:0] ph;
    int         cnt;
  } vec_t;

  vec_t vq[$];
  int   ncnt = 0;

  function automatic logic [8:0] strobes();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [2:0] op, input logic z, input logic g,
                      input logic [8:0] s, input logic [2:0] ph);
    vec_t v;
    v.op = op; v.z = z; v.g = g; v.strb = s; v.ph = ph; v.cnt = ncnt;
    vq.push_back(v);
  endtask

  // opcode is presented only in phase 3; other fetch phases carry its
  // complement, which must be ignored
  task automatic add_fetch(input logic [2:0] op, input logic [7:0] zm, input logic [7:0] gm);
    addv(~op, zm[0], gm[0], S_P0, 3'd0);
    addv(~op, zm[1], gm[1], S_P1, 3'd1);
    addv(~op, zm[2], gm[2], S_P2, 3'd2);
    addv( op, zm[3], gm[3], S_P2, 3'd3);
  endtask

  task automatic add_instr(input logic [2:0] op, input logic [7:0] zm, input logic [7:0] gm,
                           input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7);
    add_fetch(op, zm, gm);
    addv(~op, zm[4], gm[4], e4, 3'd4);
    addv(~op, zm[5], gm[5], e5, 3'd5);
    addv(~op, zm[6], gm[6], e6, 3'd6);
    addv(~op, zm[7], gm[7], e7, 3'd7);
    ncnt++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 3'b000; zero = 1'b0; go = 1'b0;

    // ADD with go pulses while running (ignored)
    add_instr(3'b010, 8'h00, 8'b0010_0010, S_INC, S_RD, S_RD, S_RDAC);
    // SKZ, zero=1: PC skip in phase 6
    add_instr(3'b001, 8'hFF, 8'h00, S_INC, S_NONE, S_INC, S_NONE);
    // SKZ, zero=0 at phase 6 (zero high in 5 and 7 must not matter)
    add_instr(3'b001, 8'b1010_0000, 8'h00, S_INC, S_NONE, S_NONE, S_NONE);
    add_instr(3'b110, 8'h00, 8'h00, S_INC, S_NONE, S_DE, S_WRDE);
    add_instr(3'b111, 8'h00, 8'h00, S_INC, S_NONE, S_LDPC, S_LDPC);
    // HLT: go in first phase-4 cycle ignored, go 3 cycles later resumes
    add_fetch(3'b000, 8'h00, 8'h00);
    addv(3'b111, 1'b0, 1'b1, S_INCH, 3'd4);
    addv(3'b111, 1'b0, 1'b0, S_HALT, 3'd4);
    addv(3'b111, 1'b0, 1'b0, S_HALT, 3'd4);
    addv(3'b111, 1'b1, 1'b1, S_HALT, 3'd4);
    addv(3'b111, 1'b1, 1'b0, S_NONE, 3'd5);
    addv(3'b111, 1'b1, 1'b0, S_NONE, 3'd6);
    addv(3'b111, 1'b0, 1'b0, S_NONE, 3'd7);
    ncnt++;
    add_instr(3'b010, 8'h00, 8'h00, S_INC, S_RD, S_RD, S_RDAC);

    // reset state
    #12;
    chk("reset strobes", strobes(), S_P0);
    chk("reset phase", phase, 0);
    chk("reset cnt", instr_cnt, 0);
    rst = 1'b0;

    foreach (vq[i]) begin
      opcode = vq[i].op; zero = vq[i].z; go = vq[i].g;
      #1;
      chk($sformatf("row%0d strobes", i), strobes(), vq[i].strb);
      chk($sformatf("row%0d phase", i), phase, vq[i].ph);
      chk($sformatf("row%0d cnt", i), instr_cnt, vq[i].cnt);
      @(posedge clk);
      #1;
    end
    go = 1'b0; zero = 1'b0;
    chk("cnt after table", instr_cnt, 7);

    // reset during phase 6 of an ADD
    opcode = 3'b010;
    step(6);
    chk("mid-add phase", phase, 6);
    chk("mid-add rd", rd, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst strobes", strobes(), S_P0);
    chk("async rst phase", phase, 0);
    chk("async rst cnt", instr_cnt, 0);
    @(posedge clk); #1;
    chk("held rst phase", phase, 0);
    chk("held rst ld_ac", ld_ac, 0);
    chk("held rst cnt", instr_cnt, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("post rst phase", phase, 0);
    step(1);
    chk("first fetch phase", phase, 1);

    // reset while halted
    opcode = 3'b000;
    step(3);
    step(1);
    chk("halt entry phase", phase, 4);
    step(1);
    chk("halted phase", phase, 4);
    chk("halted strobes", strobes(), S_HALT);
    #2 rst = 1'b1;
    #1;
    chk("rst halted strobes", strobes(), S_P0);
    chk("rst halted phase", phase, 0);
    @(negedge clk); rst = 1'b0;

    // narrow counter wrap across 17 ADDs
    opcode = 3'b010;
    for (int k = 1; k <= 17; k++) begin
      step(8);
      if (k >= 15) chk($sformatf("cnt4 after %0d", k), instr_cnt4, k % 16);
    end
    chk("cnt16 after 17", instr_cnt, 17);
    chk("cnt4 phase", phase4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/risc_controller.md
# risc_controller

Instruction sequencer for the 8-bit RISC core. It steps every instruction through a fixed 8-phase fetch/execute cycle. In each phase it drives the control strobes for the program counter, instruction register, memory, accumulator and ALU, decoding the 3-bit opcode shared with the ALU. It also handles the halt/resume handshake and counts retired instructions.

## Interface
- CNT_WIDTH, 16, width of the retired-instruction counter
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  3  instruction register opcode field (000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP)
- zero  input  1  accumulator-is-zero flag from the ALU (a_is_zero)
- go  input  1  resume request, honoured only while halted
- sel  output  1  address mux selects PC (1) or IR address field (0)
- rd  output  1  memory read enable
- ld_ir  output  1  load instruction register
- inc_pc  output  1  increment program counter
- ld_pc  output  1  load program counter from IR address field
- ld_ac  output  1  load accumulator from ALU output
- wr  output  1  memory write strobe
- data_e  output  1  drive accumulator onto data bus
- halt  output  1  processor halted / halting
- phase  output  3  current phase number
- instr_cnt  output  CNT_WIDTH  retired-instruction count

## Operation
- State consists of:
  - phase_q: 3-bit counter.
  - halted_q: halt flag.
  - op_q: latched opcode.
  - instr_cnt.
- op_q captures `opcode` on the edge that ends phase 3. The opcode input is ignored in every other phase.
- Decode terms: ALUOP = op_q in {ADD, AND, XOR, LDA}; HLT, SKZ, STO and JMP are decoded the same way from op_q.
- Outputs are combinational from phase_q, op_q, halted_q and zero. Any output not listed for a phase is 0.
  - Phase 0: sel.
  - Phase 1: sel, rd.
  - Phase 2: sel, rd, ld_ir.
  - Phase 3: sel, rd, ld_ir.
  - Phase 4: inc_pc = !halted_q; halt = HLT.
  - Phase 5: rd = ALUOP.
  - Phase 6: rd = ALUOP; inc_pc = SKZ & zero; ld_pc = JMP; data_e = STO.
  - Phase 7: rd = ALUOP; ld_ac = ALUOP; ld_pc = JMP; wr = STO; data_e = STO.
- Phase advance: phase_q increments by 1 per cycle and wraps from 7 to 0. It holds in two cases:
  - phase_q = 4, HLT and !halted_q: halted_q is set and phase_q stays 4.
  - halted_q = 1 and go = 0: phase_q stays 4.
- While halted: halt = 1 and every other strobe is 0; inc_pc is suppressed, so the PC advances exactly once per HLT.
- Resume: go = 1 on an edge while halted_q = 1 clears halted_q and moves phase_q to 5. The HLT instruction then finishes phases 5–7 with no strobes.
- go is ignored when halted_q = 0, including the first phase-4 cycle of an HLT.
- instr_cnt increments on every 7→0 phase transition and wraps modulo 2^CNT_WIDTH.

## Timing
- Reset values:
  - Registers: phase_q = 0, halted_q = 0, op_q = 000, instr_cnt = 0.
  - Outputs: sel = 1, all other strobes 0, halt = 0, phase = 0.
- Reset may be asserted mid-instruction, including while halted. It takes effect immediately and asynchronously. The first fetch begins in the cycle after the first rising edge with rst low.
- Non-HLT instruction: exactly 8 cycles; throughput of 1 instruction per 8 clocks.
- Opcode setup: `opcode` must be stable before the rising edge that ends phase 3. The IR is loaded during phases 2–3.
- SKZ samples zero combinationally during phase 6 only.
- HLT with go asserted N cycles after the halt cycle: the instruction lasts 8 + N cycles. halt is high from the first phase-4 cycle through the cycle in which go is sampled.
- instr_cnt updates one edge after phase 7. A held reset does not count.

## Test plan
- ADD (010) after reset:
  - Phases 0–3 show sel, with rd from phase 1 and ld_ir in phases 2–3.
  - Phase 4 shows inc_pc only.
  - Phases 5–7 show rd; phase 7 adds ld_ac.
  - instr_cnt = 1 after 8 cycles.
- SKZ (001):
  - zero = 1: inc_pc pulses in phase 4 and again in phase 6.
  - zero = 0: inc_pc pulses in phase 4 only.
  - ld_ac = 0 in both cases.
- STO (110) then JMP (111):
  - STO: data_e in phases 6–7, wr in phase 7 only, rd = 0 in phases 5–7.
  - JMP: ld_pc in phases 6–7, wr = 0.
- HLT (000), go raised 3 cycles after the halt cycle:
  - phase holds at 4 for 4 cycles; halt = 1 throughout; inc_pc = 1 only in the first cycle.
  - phase then goes 5, 6, 7, 0; instr_cnt increments once.
  - go pulses sent while not halted have no effect.
- rst asserted during phase 6 of an ADD, and again while halted:
  - Outputs return to reset values immediately (sel = 1, halt = 0, phase = 0).
  - instr_cnt is cleared and no ld_ac is issued.
- CNT_WIDTH = 4, 17 back-to-back ADDs: instr_cnt reads 15, then 0, then 1.
